// File: rtl/wb_word_serializer.sv
// Serializes 128-bit cache line writes into four 32-bit word write pulses for the memory monitor.
// Define WB_WORD_MASK_EN to add the mem_wmask port; clear mask bits skip their words.
module wb_word_serializer #(
  parameter int unsigned GAP   = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_write,
  input  logic [27:0]      mem_addr,
  input  logic [127:0]     mem_wdata,
`ifdef WB_WORD_MASK_EN
  input  logic [3:0]       mem_wmask,
`endif
  output logic             mem_ready,
  output logic [29:0]      addr,
  output logic [31:0]      data,
  output logic             wen,
  output logic [CNT_W-1:0] word_cnt
);

  // state  | meaning
  // S_IDLE | waiting for mem_write; the line buffer is loaded on accept
  // S_EMIT | wen pulse for word idx
  // S_GAP  | idle cycles after a pulse; gap counter runs down to zero
  // S_DONE | mem_ready pulse; mem_write is ignored here
  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_GAP, S_DONE} state_t;

  localparam logic [3:0] GAP_LD = 4'(GAP);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       gap_q, gap_d;
  logic [27:0]      line_addr_q, line_addr_d;
  logic [127:0]     line_data_q, line_data_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0]       req_mask;
  logic [2:0]       nxt;
  logic             wen_q, wen_d;
  logic             ready_q, ready_d;
  logic [29:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef WB_WORD_MASK_EN
  assign req_mask = mem_wmask;
`else
  assign req_mask = 4'hF;
`endif

  // Lowest set mask bit at or above 'from'; bit 2 of the result flags "none left".
  function automatic logic [2:0] next_word(input logic [3:0] m, input logic [2:0] from);
    next_word = 3'b100;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (3'(i) >= from)) next_word = {1'b0, 2'(i)};
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    line_addr_d = line_addr_q;
    line_data_d = line_data_q;
    mask_d      = mask_q;
    nxt         = 3'b100;
    unique case (state_q)
      S_IDLE: begin
        if (mem_write) begin
          line_addr_d = mem_addr;
          line_data_d = mem_wdata;
          mask_d      = req_mask;
          nxt         = next_word(req_mask, 3'd0);
          if (nxt[2]) begin
            state_d = S_DONE;
          end else begin
            idx_d   = nxt[1:0];
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        gap_d   = GAP_LD;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q <= 4'd1) begin
          gap_d = 4'd0;
          nxt   = next_word(mask_q, {1'b0, idx_q} + 3'd1);
          if (nxt[2]) begin
            state_d = S_DONE;
          end else begin
            idx_d   = nxt[1:0];
            state_d = S_EMIT;
          end
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they are registered yet line up with it.
  always_comb begin
    wen_d   = (state_d == S_EMIT);
    ready_d = (state_d == S_DONE);
    addr_d  = wen_d ? {line_addr_d, idx_d} : addr_q;
    data_d  = wen_d ? line_data_d[{idx_d, 5'd0} +: 32] : data_q;
    cnt_d   = (wen_d && !(&cnt_q)) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      gap_q       <= 4'd0;
      line_addr_q <= 28'd0;
      line_data_q <= 128'd0;
      mask_q      <= 4'hF;
      wen_q       <= 1'b0;
      ready_q     <= 1'b0;
      addr_q      <= 30'd0;
      data_q      <= 32'd0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      line_addr_q <= line_addr_d;
      line_data_q <= line_data_d;
      mask_q      <= mask_d;
      wen_q       <= wen_d;
      ready_q     <= ready_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_ready = ready_q;
  assign addr      = addr_q;
  assign data      = data_q;
  assign wen       = wen_q;
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_wb_word_serializer.sv
// Scoreboard bench for wb_word_serializer: three instances (GAP=1, GAP=3, CNT_W=4 saturation).
// Expected pulses/ready events are queued at request time and popped by per-instance monitors.
module tb_wb_word_serializer;

  typedef struct {
    bit          rdy;
    int          cyc;
    logic [29:0] a;
    logic [31:0] d;
    int          cnt;
  } evt_t;

`ifdef WB_WORD_MASK_EN
  localparam bit MASK_ON = 1'b1;
`else
  localparam bit MASK_ON = 1'b0;
`endif

  localparam logic [127:0] L1 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] L2 = 128'h00000008_00000007_00000006_00000005;
  localparam logic [127:0] L3 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

  logic         clk = 1'b0;
  logic         rst;
  logic         mw [3];
  logic [27:0]  ma [3];
  logic [127:0] md [3];
  logic [3:0]   mm [3];

  logic         rdy0, rdy1, rdy2;
  logic         wen0, wen1, wen2;
  logic [29:0]  ad0, ad1, ad2;
  logic [31:0]  dt0, dt1, dt2;
  logic [15:0]  cnt0, cnt1;
  logic [3:0]   cnt2;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt [3];
  bit   prev_w [3];
  evt_t q0 [$];
  evt_t q1 [$];
  evt_t q2 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wb_word_serializer #(.GAP(1), .CNT_W(16)) u_g1 (
    .clk(clk), .rst(rst), .mem_write(mw[0]), .mem_addr(ma[0]), .mem_wdata(md[0]),
`ifdef WB_WORD_MASK_EN
    .mem_wmask(mm[0]),
`endif
    .mem_ready(rdy0), .addr(ad0), .data(dt0), .wen(wen0), .word_cnt(cnt0));

  wb_word_serializer #(.GAP(3), .CNT_W(16)) u_g3 (
    .clk(clk), .rst(rst), .mem_write(mw[1]), .mem_addr(ma[1]), .mem_wdata(md[1]),
`ifdef WB_WORD_MASK_EN
    .mem_wmask(mm[1]),
`endif
    .mem_ready(rdy1), .addr(ad1), .data(dt1), .wen(wen1), .word_cnt(cnt1));

  wb_word_serializer #(.GAP(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .mem_write(mw[2]), .mem_addr(ma[2]), .mem_wdata(md[2]),
`ifdef WB_WORD_MASK_EN
    .mem_wmask(mm[2]),
`endif
    .mem_ready(rdy2), .addr(ad2), .data(dt2), .wen(wen2), .word_cnt(cnt2));

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc + 1);
    end
  endfunction

  function automatic int gap_of(input int inst);
    return (inst == 1) ? 3 : 1;
  endfunction

  function automatic int cmax(input int inst);
    return (inst == 2) ? 15 : 65535;
  endfunction

  function automatic void push(input int inst, input evt_t e);
    case (inst)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic bit pop(input int inst, output evt_t e);
    e.rdy = 1'b0; e.cyc = 0; e.a = '0; e.d = '0; e.cnt = 0;
    case (inst)
      0:       if (q0.size() == 0) return 1'b0; else e = q0.pop_front();
      1:       if (q1.size() == 0) return 1'b0; else e = q1.pop_front();
      default: if (q2.size() == 0) return 1'b0; else e = q2.pop_front();
    endcase
    return 1'b1;
  endfunction

  function automatic logic rdy_of(input int inst);
    case (inst)
      0:       return rdy0;
      1:       return rdy1;
      default: return rdy2;
    endcase
  endfunction

  // Expected event list: pulses every GAP+1 cycles from k+1 for each enabled word, ready right after.
  function automatic void push_line(input int inst, input int k, input logic [27:0] la,
                                    input logic [127:0] wd, input logic [3:0] mask, input int lim);
    int t;
    int n;
    logic [3:0] m;
    evt_t e;
    t = k + 1;
    n = 0;
    m = MASK_ON ? mask : 4'hF;
    for (int i = 0; i < 4; i++) begin
      if (m[i] && n < lim) begin
        if (exp_cnt[inst] < cmax(inst)) exp_cnt[inst] = exp_cnt[inst] + 1;
        e.rdy = 1'b0;
        e.cyc = t;
        e.a   = {la, 2'(i)};
        e.d   = wd[32*i +: 32];
        e.cnt = exp_cnt[inst];
        push(inst, e);
        t = t + gap_of(inst) + 1;
        n++;
      end
    end
    if (lim >= 4) begin
      e.rdy = 1'b1; e.cyc = t; e.a = '0; e.d = '0; e.cnt = 0;
      push(inst, e);
    end
  endfunction

  task automatic mon(input int inst, input logic w, input logic r, input logic [29:0] a,
                     input logic [31:0] d, input int cnt);
    evt_t e;
    if (w) chk($sformatf("i%0d_no_adjacent_wen", inst), 64'(prev_w[inst]), 64'd0);
    prev_w[inst] = w;
    if (w || r) begin
      if (!pop(inst, e)) begin
        chk($sformatf("i%0d_unexpected_event", inst), {62'd0, w, r}, 64'd0);
      end else begin
        chk($sformatf("i%0d_event_kind", inst), {62'd0, w, r}, e.rdy ? 64'd1 : 64'd2);
        chk($sformatf("i%0d_event_cycle", inst), 64'(cyc + 1), 64'(e.cyc));
        if (w && !e.rdy) begin
          chk($sformatf("i%0d_addr", inst), 64'(a), 64'(e.a));
          chk($sformatf("i%0d_data", inst), 64'(d), 64'(e.d));
          chk($sformatf("i%0d_word_cnt", inst), 64'(cnt), 64'(e.cnt));
        end
      end
    end
  endtask

  always @(negedge clk) mon(0, wen0, rdy0, ad0, dt0, int'(cnt0));
  always @(negedge clk) mon(1, wen1, rdy1, ad1, dt1, int'(cnt1));
  always @(negedge clk) mon(2, wen2, rdy2, ad2, dt2, int'(cnt2));

  task automatic send_line(input int inst, input logic [27:0] la, input logic [127:0] wd,
                           input logic [3:0] mask);
    int  k;
    bit  seen;
    @(negedge clk);
    mw[inst] = 1'b1;
    ma[inst] = la;
    md[inst] = wd;
    mm[inst] = mask;
    k = cyc + 1;
    push_line(inst, k, la, wd, mask, 4);
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = rdy_of(inst);
    end
    mw[inst] = 1'b0;
    chk($sformatf("i%0d_ready_seen", inst), 64'(seen), 64'd1);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mw[i] = 1'b0; ma[i] = '0; md[i] = '0; mm[i] = 4'hF;
      exp_cnt[i] = 0; prev_w[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_wen", 64'(wen0), 64'd0);
    chk("reset_addr", 64'(ad0), 64'd0);
    chk("reset_data", 64'(dt0), 64'd0);
    chk("reset_ready", 64'(rdy0), 64'd0);
    chk("reset_cnt", 64'(cnt0), 64'd0);

    // basic line then a back-to-back line raised the cycle after mem_ready
    send_line(0, 28'h0000001, L1, 4'hF);
    chk("cnt_after_line1", 64'(cnt0), 64'd4);
    send_line(0, 28'h0000002, L2, 4'hF);
    chk("cnt_after_line2", 64'(cnt0), 64'd8);

    // reset during the gap after the second pulse
    @(negedge clk);
    mw[0] = 1'b1; ma[0] = 28'h0000003; md[0] = L3; mm[0] = 4'hF;
    k = cyc + 1;
    push_line(0, k, 28'h0000003, L3, 4'hF, 2);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    mw[0] = 1'b0;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    @(negedge clk);
    chk("midreset_wen", 64'(wen0), 64'd0);
    chk("midreset_addr", 64'(ad0), 64'd0);
    chk("midreset_cnt", 64'(cnt0), 64'd0);
    chk("midreset_ready", 64'(rdy0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midreset_queue_drained", 64'(q0.size()), 64'd0);
    send_line(0, 28'h0000003, L3, 4'hF);
    chk("cnt_after_reset_line", 64'(cnt0), 64'd4);

`ifdef WB_WORD_MASK_EN
    send_line(0, 28'hABCDEF0, L2, 4'b1010);
    chk("cnt_after_mask1010", 64'(cnt0), 64'd6);
    send_line(0, 28'h0000005, L1, 4'b0000);
    chk("cnt_after_mask0000", 64'(cnt0), 64'd6);
`endif

    send_line(1, 28'h0000001, L1, 4'hF);
    chk("gap3_cnt", 64'(cnt1), 64'd4);

    for (int l = 0; l < 5; l++) send_line(2, 28'(16 + l), L2 ^ 128'(l), 4'hF);
    chk("sat_cnt", 64'(cnt2), 64'hF);

    repeat (5) @(negedge clk);
    chk("q0_empty", 64'(q0.size()), 64'd0);
    chk("q1_empty", 64'(q1.size()), 64'd0);
    chk("q2_empty", 64'(q2.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_word_serializer.md
# wb_word_serializer

Sits between the D-cache write-back port and the data-memory write monitor (TestBed). Accepts 128-bit line writes from the cache through a request/ready handshake and replays them as a stream of 32-bit word writes (addr, data, wen). Each write is a one-cycle wen pulse followed by at least one idle cycle, matching the monitor's pulse-per-write sampling. It also counts emitted words for run statistics.

## Interface
- GAP, 1: idle (wen=0) cycles after every word pulse; legal range 1..15.
- CNT_W, 16: width of the emitted-word counter.
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_write  input  1  line write request; held high until mem_ready.
- mem_addr  input  28  line address (16-byte line).
- mem_wdata  input  128  line data; word i = mem_wdata[32i+31:32i].
- mem_wmask  input  4  per-word write enable (present only with WB_WORD_MASK_EN).
- mem_ready  output  1  one-cycle pulse: line fully emitted.
- addr  output  30  word address to monitor.
- data  output  32  word data, passed through unmodified (no byte swap).
- wen  output  1  word write strobe.
- word_cnt  output  CNT_W  total words emitted since reset, saturating.

## Operation
- States: IDLE, EMIT, GAP, DONE.
- IDLE: when mem_write=1, capture mem_addr, mem_wdata (and mask) into the line buffer. Set idx=0 and go to EMIT. Otherwise stay.
- EMIT:
  - Drive addr={line_addr, idx[1:0]}, data=word[idx], wen=1 for exactly one cycle.
  - Increment word_cnt, holding at all-ones.
  - Load gap counter with GAP and go to GAP.
- GAP: wen=0 and addr/data hold their last values. Decrement the gap counter. When it reaches 0:
  - if idx=3, go to DONE;
  - else idx+1 and go to EMIT.
- DONE: mem_ready=1 for one cycle, then IDLE. mem_write is ignored in DONE.
- In IDLE the following cycle, a still-high mem_write is treated as a new request. Upstream must drop mem_write on the cycle it samples mem_ready.
- Words are emitted in ascending order 0..3. Address arithmetic has no carry into line_addr.
- Inputs are ignored in every state except IDLE; the line buffer is stable through the whole emission.
- All outputs are registered; none is combinational from inputs.

## Timing
- Reset values: addr=0, data=0, wen=0, mem_ready=0, word_cnt=0, state=IDLE, idx=0.
- Reset asserted mid-line aborts immediately: wen drops and no mem_ready is issued. The remaining words are lost.
- With request accepted on edge k and all 4 words emitted:
  - wen=1 during cycles k+1, k+2+GAP, k+3+2·GAP, k+4+3·GAP;
  - mem_ready=1 during cycle k+5+4·GAP;
  - for GAP=1: pulses at k+1/3/5/7, ready at k+9.
- Minimum spacing between consecutive wen pulses is GAP+1 cycles. wen is never high two cycles in a row.
- word_cnt updates in the same cycle wen is high.
- Back-to-back lines: the earliest next acceptance is the cycle after mem_ready.

## Configuration
- WB_WORD_MASK_EN defined:
  - mem_wmask is captured with the line.
  - In EMIT, a word whose mask bit is 0 produces no pulse and no gap. idx advances to the next set bit in the same cycle; there are no skip cycles.
  - If the captured mask is 4'b0000, go IDLE→DONE directly, giving mem_ready at k+1.
  - word_cnt counts only emitted words.
- WB_WORD_MASK_EN undefined:
  - The mem_wmask port does not exist.
  - All 4 words are always emitted.

## Test plan
- Basic line, GAP=1, mask off:
  - Stimulus: mem_addr=28'h0000001, mem_wdata=128'h00000004_00000003_00000002_00000001.
  - Required: pulses (30'h4,32'h1), (30'h5,32'h2), (30'h6,32'h3), (30'h7,32'h4) at k+1/3/5/7, mem_ready at k+9, word_cnt=4.
- Back-to-back lines:
  - Stimulus: mem_write re-raised the cycle after mem_ready with mem_addr=28'h0000002.
  - Required: first pulse addr=30'h8 at ready+2, word_cnt=8, no two adjacent wen cycles.
- GAP=3:
  - Stimulus: same first line as the basic test.
  - Required: pulses at k+1/5/9/13, mem_ready at k+17.
- Reset mid-line:
  - Stimulus: rst pulse after the second pulse.
  - Required: wen=0, addr=0, word_cnt=0, no mem_ready.
  - Then a new request emits from word 0.
- WB_WORD_MASK_EN, mask=4'b1010:
  - Required: only addr {A,2'd1} and {A,2'd3} pulse, at k+1 and k+3. mem_ready at k+5, word_cnt=2.
  - Follow-up: mask=4'b0000 gives mem_ready at k+1 with no wen.
- Saturation, CNT_W=4:
  - Stimulus: 5 lines.
  - Required: word_cnt holds at 4'hF after word 15 and stays there.
